// File: rtl/fabric_arbiter.sv
// fabric_arbiter: shares one single-outstanding OCP slave port between an
// instruction master and a data master (round-robin or data-priority).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef BEN_WIDTH
`define BEN_WIDTH 4
`endif
`ifndef OCP_CMD_IDLE
`define OCP_CMD_IDLE 3'b000
`endif
`ifndef OCP_RESP_NULL
`define OCP_RESP_NULL 2'b00
`endif

module fabric_arbiter #(
   parameter int PRIO_MODE    = 0,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                   clk,
   input  logic                   nrst,
   input  logic [`ADDR_WIDTH-1:0] i_I_MAddr,
   input  logic [2:0]             i_I_MCmd,
   input  logic [`DATA_WIDTH-1:0] i_I_MData,
   input  logic [`BEN_WIDTH-1:0]  i_I_MByteEn,
   output logic                   o_I_SCmdAccept,
   output logic [`DATA_WIDTH-1:0] o_I_SData,
   output logic [1:0]             o_I_SResp,
   input  logic [`ADDR_WIDTH-1:0] i_D_MAddr,
   input  logic [2:0]             i_D_MCmd,
   input  logic [`DATA_WIDTH-1:0] i_D_MData,
   input  logic [`BEN_WIDTH-1:0]  i_D_MByteEn,
   output logic                   o_D_SCmdAccept,
   output logic [`DATA_WIDTH-1:0] o_D_SData,
   output logic [1:0]             o_D_SResp,
   output logic [`ADDR_WIDTH-1:0] o_P_MAddr,
   output logic [2:0]             o_P_MCmd,
   output logic [`DATA_WIDTH-1:0] o_P_MData,
   output logic [`BEN_WIDTH-1:0]  o_P_MByteEn,
   input  logic                   i_P_SCmdAccept,
   input  logic [`DATA_WIDTH-1:0] i_P_SData,
   input  logic [1:0]             i_P_SResp,
   output logic [1:0]             o_grant
);

   typedef enum logic [4:0] {
      ST_IDLE  = 5'b00001,
      ST_GNT_I = 5'b00010,
      ST_GNT_D = 5'b00100,
      ST_RSP_I = 5'b01000,
      ST_RSP_D = 5'b10000
   } state_t;

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   state_t     state_q, state_d;
   logic       last_d_q, last_d_d;
   logic [3:0] starve_q, starve_d;
   logic       i_pend, d_pend, rsp_valid, tie_to_i;

   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

   assign i_pend    = (i_I_MCmd != `OCP_CMD_IDLE);
   assign d_pend    = (i_D_MCmd != `OCP_CMD_IDLE);
   assign rsp_valid = (i_P_SResp != `OCP_RESP_NULL);
   // On a tie, round-robin favours whoever was not served last; priority mode
   // favours D until it has starved I for LIMIT consecutive grants.
   assign tie_to_i  = (PRIO_MODE == 0) ? last_d_q : (starve_q == LIMIT);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q  <= ST_IDLE;
         last_d_q <= 1'b1;
         starve_q <= 4'd0;
      end else begin
         state_q  <= state_d;
         last_d_q <= last_d_d;
         starve_q <= starve_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      last_d_d = last_d_q;
      starve_d = starve_q;
      unique case (state_q)
         ST_IDLE: begin
            if (i_pend && (!d_pend || tie_to_i)) begin
               state_d  = ST_GNT_I;
               last_d_d = 1'b0;
               starve_d = 4'd0;
            end else if (d_pend) begin
               state_d  = ST_GNT_D;
               last_d_d = 1'b1;
               starve_d = i_pend ? sat_inc4(starve_q) : 4'd0;
            end else begin
               starve_d = 4'd0;
            end
         end
         ST_GNT_I: if (i_P_SCmdAccept) state_d = rsp_valid ? ST_IDLE : ST_RSP_I;
         ST_GNT_D: if (i_P_SCmdAccept) state_d = rsp_valid ? ST_IDLE : ST_RSP_D;
         ST_RSP_I: if (rsp_valid) state_d = ST_IDLE;
         ST_RSP_D: if (rsp_valid) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      o_P_MAddr      = '0;
      o_P_MCmd       = `OCP_CMD_IDLE;
      o_P_MData      = '0;
      o_P_MByteEn    = '0;
      o_I_SCmdAccept = !i_pend;
      o_D_SCmdAccept = !d_pend;
      o_I_SData      = '0;
      o_I_SResp      = `OCP_RESP_NULL;
      o_D_SData      = '0;
      o_D_SResp      = `OCP_RESP_NULL;
      unique case (state_q)
         ST_GNT_I: begin
            o_P_MAddr      = i_I_MAddr;
            o_P_MCmd       = i_I_MCmd;
            o_P_MData      = i_I_MData;
            o_P_MByteEn    = i_I_MByteEn;
            o_I_SCmdAccept = i_P_SCmdAccept;
            o_I_SData      = i_P_SData;
            o_I_SResp      = i_P_SResp;
         end
         ST_GNT_D: begin
            o_P_MAddr      = i_D_MAddr;
            o_P_MCmd       = i_D_MCmd;
            o_P_MData      = i_D_MData;
            o_P_MByteEn    = i_D_MByteEn;
            o_D_SCmdAccept = i_P_SCmdAccept;
            o_D_SData      = i_P_SData;
            o_D_SResp      = i_P_SResp;
         end
         ST_RSP_I: begin
            o_I_SData = i_P_SData;
            o_I_SResp = i_P_SResp;
         end
         ST_RSP_D: begin
            o_D_SData = i_P_SData;
            o_D_SResp = i_P_SResp;
         end
         default: ;
      endcase
   end

   assign o_grant = {(state_q == ST_GNT_D) || (state_q == ST_RSP_D),
                     (state_q == ST_GNT_I) || (state_q == ST_RSP_I)};

endmodule

// File: tb/tb_fabric_arbiter.sv
// Self-checking bench for fabric_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef BEN_WIDTH
`define BEN_WIDTH 4
`endif
`ifndef OCP_CMD_IDLE
`define OCP_CMD_IDLE 3'b000
`endif
`ifndef OCP_RESP_NULL
`define OCP_RESP_NULL 2'b00
`endif

module tb_fabric_arbiter;
   localparam int AW = `ADDR_WIDTH;
   localparam int DW = `DATA_WIDTH;
   localparam int BW = `BEN_WIDTH;
   localparam logic [2:0] CMD_IDLE = 3'b000;
   localparam logic [2:0] CMD_WR   = 3'b001;
   localparam logic [2:0] CMD_RD   = 3'b010;
   localparam logic [1:0] R_NULL   = 2'b00;
   localparam logic [1:0] R_DVA    = 2'b01;
   localparam logic [1:0] R_ERR    = 2'b11;
   localparam int LIMIT_PR = 2;

   logic clk = 1'b0;
   logic nrst;
   always #5 clk = ~clk;

   logic [AW-1:0] I_MAddr, D_MAddr;
   logic [2:0]    I_MCmd, D_MCmd;
   logic [DW-1:0] I_MData, D_MData, P_SData;
   logic [BW-1:0] I_MByteEn, D_MByteEn;
   logic          P_acc;
   logic [1:0]    P_resp;

   logic          rr_I_acc, rr_D_acc, pr_I_acc, pr_D_acc;
   logic [DW-1:0] rr_I_SData, rr_D_SData, pr_I_SData, pr_D_SData;
   logic [1:0]    rr_I_SResp, rr_D_SResp, pr_I_SResp, pr_D_SResp;
   logic [AW-1:0] rr_P_MAddr, pr_P_MAddr;
   logic [2:0]    rr_P_MCmd, pr_P_MCmd;
   logic [DW-1:0] rr_P_MData, pr_P_MData;
   logic [BW-1:0] rr_P_MByteEn, pr_P_MByteEn;
   logic [1:0]    rr_grant, pr_grant;

   int n_tests = 0;
   int n_fail  = 0;
   bit mode_sel = 1'b0;

   fabric_arbiter #(.PRIO_MODE(0), .STARVE_LIMIT(4)) dut_rr (
      .clk(clk), .nrst(nrst),
      .i_I_MAddr(I_MAddr), .i_I_MCmd(I_MCmd), .i_I_MData(I_MData), .i_I_MByteEn(I_MByteEn),
      .o_I_SCmdAccept(rr_I_acc), .o_I_SData(rr_I_SData), .o_I_SResp(rr_I_SResp),
      .i_D_MAddr(D_MAddr), .i_D_MCmd(D_MCmd), .i_D_MData(D_MData), .i_D_MByteEn(D_MByteEn),
      .o_D_SCmdAccept(rr_D_acc), .o_D_SData(rr_D_SData), .o_D_SResp(rr_D_SResp),
      .o_P_MAddr(rr_P_MAddr), .o_P_MCmd(rr_P_MCmd), .o_P_MData(rr_P_MData), .o_P_MByteEn(rr_P_MByteEn),
      .i_P_SCmdAccept(P_acc), .i_P_SData(P_SData), .i_P_SResp(P_resp),
      .o_grant(rr_grant)
   );

   fabric_arbiter #(.PRIO_MODE(1), .STARVE_LIMIT(LIMIT_PR)) dut_pr (
      .clk(clk), .nrst(nrst),
      .i_I_MAddr(I_MAddr), .i_I_MCmd(I_MCmd), .i_I_MData(I_MData), .i_I_MByteEn(I_MByteEn),
      .o_I_SCmdAccept(pr_I_acc), .o_I_SData(pr_I_SData), .o_I_SResp(pr_I_SResp),
      .i_D_MAddr(D_MAddr), .i_D_MCmd(D_MCmd), .i_D_MData(D_MData), .i_D_MByteEn(D_MByteEn),
      .o_D_SCmdAccept(pr_D_acc), .o_D_SData(pr_D_SData), .o_D_SResp(pr_D_SResp),
      .o_P_MAddr(pr_P_MAddr), .o_P_MCmd(pr_P_MCmd), .o_P_MData(pr_P_MData), .o_P_MByteEn(pr_P_MByteEn),
      .i_P_SCmdAccept(P_acc), .i_P_SData(P_SData), .i_P_SResp(P_resp),
      .o_grant(pr_grant)
   );

   // Outputs of whichever instance the randomized test is currently driving.
   logic [1:0]             sel_grant;
   logic [3+AW+DW+BW-1:0]  sel_req;
   logic                   sel_I_acc, sel_D_acc;
   logic [2+DW-1:0]        sel_I_rsp, sel_D_rsp;
   assign sel_grant = mode_sel ? pr_grant : rr_grant;
   assign sel_req   = mode_sel ? {pr_P_MCmd, pr_P_MAddr, pr_P_MData, pr_P_MByteEn}
                               : {rr_P_MCmd, rr_P_MAddr, rr_P_MData, rr_P_MByteEn};
   assign sel_I_acc = mode_sel ? pr_I_acc : rr_I_acc;
   assign sel_D_acc = mode_sel ? pr_D_acc : rr_D_acc;
   assign sel_I_rsp = mode_sel ? {pr_I_SResp, pr_I_SData} : {rr_I_SResp, rr_I_SData};
   assign sel_D_rsp = mode_sel ? {pr_D_SResp, pr_D_SData} : {rr_D_SResp, rr_D_SData};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      I_MCmd = CMD_IDLE; I_MAddr = '0; I_MData = '0; I_MByteEn = '0;
      D_MCmd = CMD_IDLE; D_MAddr = '0; D_MData = '0; D_MByteEn = '0;
      P_acc = 1'b0; P_resp = R_NULL; P_SData = '0;
   endtask

   task automatic do_reset();
      nrst = 1'b0;
      idle_inputs();
      tick();
      nrst = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      I_MCmd = CMD_RD;
      I_MAddr = 32'h44;
      nrst = 1'b1;
      #2;
      nrst = 1'b0;
      #1;
      n_tests++;
      if (rr_grant !== 2'b00 || pr_grant !== 2'b00) begin
         n_fail++; $display("FAIL reset_grant: got %b/%b expected 00", rr_grant, pr_grant);
      end
      n_tests++;
      if ({rr_P_MCmd, rr_P_MAddr, rr_P_MData, rr_P_MByteEn} !== '0) begin
         n_fail++; $display("FAIL reset_p_outputs: got cmd %h addr %h expected 0", rr_P_MCmd, rr_P_MAddr);
      end
      n_tests++;
      if (rr_I_acc !== 1'b0 || rr_D_acc !== 1'b1) begin
         n_fail++; $display("FAIL reset_accepts: got I=%b D=%b expected I=0 D=1", rr_I_acc, rr_D_acc);
      end
      n_tests++;
      if ({rr_I_SResp, rr_I_SData, rr_D_SResp, rr_D_SData} !== '0) begin
         n_fail++; $display("FAIL reset_responses: got I=%h D=%h expected 0", rr_I_SResp, rr_D_SResp);
      end
   endtask

   task automatic test_i_read();
      int g01 = 0;
      do_reset();
      I_MCmd = CMD_RD; I_MAddr = 32'h100; P_acc = 1'b1; P_resp = R_NULL;
      tick();
      #1;
      if (rr_grant === 2'b01) g01++;
      n_tests++;
      if (rr_P_MCmd !== CMD_RD || rr_P_MAddr !== 32'h100 || rr_I_acc !== 1'b1) begin
         n_fail++; $display("FAIL iread_cmd: got cmd %h addr %h acc %b expected 2 100 1", rr_P_MCmd, rr_P_MAddr, rr_I_acc);
      end
      tick();
      I_MCmd = CMD_IDLE; I_MAddr = '0; P_acc = 1'b0;
      #1;
      if (rr_grant === 2'b01) g01++;
      tick();
      P_resp = R_DVA; P_SData = 32'hCAFEF00D;
      #1;
      if (rr_grant === 2'b01) g01++;
      n_tests++;
      if (rr_I_SResp !== R_DVA || rr_I_SData !== 32'hCAFEF00D) begin
         n_fail++; $display("FAIL iread_resp: got %h/%h expected 1/cafef00d", rr_I_SResp, rr_I_SData);
      end
      n_tests++;
      if (rr_D_SResp !== R_NULL || rr_D_SData !== '0 || rr_D_acc !== 1'b1) begin
         n_fail++; $display("FAIL iread_d_quiet: got %h/%h acc %b expected 0/0 acc 1", rr_D_SResp, rr_D_SData, rr_D_acc);
      end
      tick();
      P_resp = R_NULL; P_SData = '0;
      #1;
      n_tests++;
      if (rr_grant !== 2'b00) begin
         n_fail++; $display("FAIL iread_release: got %b expected 00", rr_grant);
      end
      n_tests++;
      if (g01 !== 3) begin
         n_fail++; $display("FAIL iread_grant_cycles: got %0d expected 3", g01);
      end
   endtask

   task automatic test_rr_alternation();
      logic [1:0] exp_g;
      do_reset();
      I_MCmd = CMD_RD; I_MAddr = 32'h10; D_MCmd = CMD_WR; D_MAddr = 32'h20;
      P_acc = 1'b1; P_resp = R_DVA;
      for (int k = 0; k < 4; k++) begin
         exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
         tick();
         #1;
         n_tests++;
         if (rr_grant !== exp_g) begin
            n_fail++; $display("FAIL rr_order[%0d]: got %b expected %b", k, rr_grant, exp_g);
         end
         n_tests++;
         if ((exp_g == 2'b01) ? (rr_D_acc !== 1'b0) : (rr_I_acc !== 1'b0)) begin
            n_fail++; $display("FAIL rr_loser_accept[%0d]: got I=%b D=%b expected loser 0", k, rr_I_acc, rr_D_acc);
         end
         tick();
         #1;
         n_tests++;
         if (rr_grant !== 2'b00 || rr_I_acc !== 1'b0 || rr_D_acc !== 1'b0) begin
            n_fail++; $display("FAIL rr_bubble[%0d]: got grant %b acc %b%b expected 00 00", k, rr_grant, rr_I_acc, rr_D_acc);
         end
      end
   endtask

   task automatic test_prio_starve();
      logic [1:0] exp_g;
      do_reset();
      I_MCmd = CMD_RD; I_MAddr = 32'h30; D_MCmd = CMD_RD; D_MAddr = 32'h40;
      P_acc = 1'b1; P_resp = R_DVA;
      for (int k = 0; k < 6; k++) begin
         exp_g = (k % 3 == 2) ? 2'b01 : 2'b10;
         tick();
         #1;
         n_tests++;
         if (pr_grant !== exp_g) begin
            n_fail++; $display("FAIL prio_order[%0d]: got %b expected %b", k, pr_grant, exp_g);
         end
         tick();
      end
   endtask

   task automatic test_accept_stall();
      int held = 0;
      do_reset();
      D_MCmd = CMD_WR; D_MAddr = 32'h200; D_MData = 32'h12345678; D_MByteEn = 4'hF; P_acc = 1'b0;
      tick();
      I_MCmd = CMD_RD; I_MAddr = 32'h300;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) tick();
         if (k == 3) begin P_acc = 1'b1; P_resp = R_DVA; P_SData = 32'h55; end
         #1;
         if (rr_P_MCmd === CMD_WR && rr_P_MAddr === 32'h200 && rr_P_MData === 32'h12345678 && rr_P_MByteEn === 4'hF) held++;
         n_tests++;
         if (rr_grant !== 2'b10 || rr_I_acc !== 1'b0 || rr_D_acc !== (k == 3)) begin
            n_fail++; $display("FAIL stall[%0d]: got grant %b accI %b accD %b expected 10 0 %0d", k, rr_grant, rr_I_acc, rr_D_acc, k == 3);
         end
      end
      n_tests++;
      if (held !== 4) begin
         n_fail++; $display("FAIL stall_cmd_held: got %0d cycles expected 4", held);
      end
      tick();
      D_MCmd = CMD_IDLE; P_acc = 1'b0; P_resp = R_NULL;
      #1;
      n_tests++;
      if (rr_grant !== 2'b00) begin
         n_fail++; $display("FAIL stall_bubble: got %b expected 00", rr_grant);
      end
      tick();
      #1;
      n_tests++;
      if (rr_grant !== 2'b01 || rr_P_MCmd !== CMD_RD || rr_P_MAddr !== 32'h300) begin
         n_fail++; $display("FAIL stall_i_after: got %b cmd %h addr %h expected 01 2 300", rr_grant, rr_P_MCmd, rr_P_MAddr);
      end
      P_acc = 1'b1; P_resp = R_DVA;
      tick();
      idle_inputs();
   endtask

   task automatic test_err_same_cycle();
      do_reset();
      I_MCmd = CMD_RD; I_MAddr = 32'h40; P_acc = 1'b1; P_resp = R_ERR; P_SData = 32'hDEADBEEF;
      tick();
      #1;
      n_tests++;
      if (rr_grant !== 2'b01 || rr_I_SResp !== R_ERR || rr_I_SData !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL err_forward: got %b %h %h expected 01 3 deadbeef", rr_grant, rr_I_SResp, rr_I_SData);
      end
      tick();
      I_MCmd = CMD_IDLE; I_MAddr = '0;
      #1;
      n_tests++;
      if (rr_grant !== 2'b00 || rr_I_SResp !== R_NULL || rr_I_SData !== '0 || rr_P_MCmd !== CMD_IDLE) begin
         n_fail++; $display("FAIL err_idle: got %b %h %h cmd %h expected 00 0 0 0", rr_grant, rr_I_SResp, rr_I_SData, rr_P_MCmd);
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid_rsp();
      do_reset();
      D_MCmd = CMD_RD; D_MAddr = 32'h80; P_acc = 1'b1; P_resp = R_NULL;
      tick();
      tick();
      D_MCmd = CMD_IDLE; D_MAddr = '0; P_acc = 1'b0; P_resp = R_DVA; P_SData = 32'hA5A5A5A5;
      #1;
      n_tests++;
      if (rr_grant !== 2'b10 || rr_D_SResp !== R_DVA || rr_D_SData !== 32'hA5A5A5A5) begin
         n_fail++; $display("FAIL rst_mid_before: got %b %h %h expected 10 1 a5a5a5a5", rr_grant, rr_D_SResp, rr_D_SData);
      end
      nrst = 1'b0;
      #1;
      n_tests++;
      if (rr_grant !== 2'b00 || rr_D_SResp !== R_NULL || rr_D_SData !== '0 || rr_P_MCmd !== CMD_IDLE || rr_D_acc !== 1'b1) begin
         n_fail++; $display("FAIL rst_mid_async: got %b %h %h cmd %h acc %b expected 00 0 0 0 1", rr_grant, rr_D_SResp, rr_D_SData, rr_P_MCmd, rr_D_acc);
      end
      P_resp = R_NULL; P_SData = '0;
      #1;
      nrst = 1'b1;
      D_MCmd = CMD_WR; D_MAddr = 32'h84; P_acc = 1'b1;
      tick();
      #1;
      n_tests++;
      if (rr_grant !== 2'b10 || rr_P_MCmd !== CMD_WR || rr_P_MAddr !== 32'h84) begin
         n_fail++; $display("FAIL rst_mid_regrant: got %b cmd %h addr %h expected 10 1 84", rr_grant, rr_P_MCmd, rr_P_MAddr);
      end
      P_resp = R_DVA;
      tick();
      idle_inputs();
      #1;
      n_tests++;
      if (rr_grant !== 2'b00) begin
         n_fail++; $display("FAIL rst_mid_done: got %b expected 00", rr_grant);
      end
   endtask

   // Reference model: who owns the slave (0 none, 1 I, 2 D) and whether the
   // command has already been accepted; arbitration follows the written rules.
   task automatic test_random(input bit mode, input int cycles);
      int owner, starve;
      bit accepted, last_d, gi, ip, dp, i_wait, d_wait, s_busy, i_drop, d_drop;
      logic [1:0]            e_grant;
      logic [3+AW+DW+BW-1:0] e_req;
      logic                  e_iacc, e_dacc, si_acc, sd_acc;
      logic [2+DW-1:0]       e_irsp, e_drsp, si_rsp, sd_rsp;
      logic [2:0]            sp_cmd;
      mode_sel = mode;
      do_reset();
      owner = 0; starve = 0; accepted = 0; last_d = 1;
      i_wait = 0; d_wait = 0; s_busy = 0;
      for (int c = 0; c < cycles; c++) begin
         if (I_MCmd == CMD_IDLE && !i_wait && $urandom_range(0, 1) == 1) begin
            I_MCmd = ($urandom_range(0, 1) == 1) ? CMD_RD : CMD_WR;
            I_MAddr = $urandom; I_MData = $urandom; I_MByteEn = BW'($urandom);
         end
         if (D_MCmd == CMD_IDLE && !d_wait && $urandom_range(0, 1) == 1) begin
            D_MCmd = ($urandom_range(0, 1) == 1) ? CMD_RD : CMD_WR;
            D_MAddr = $urandom; D_MData = $urandom; D_MByteEn = BW'($urandom);
         end
         #1;
         P_acc = ($urandom_range(0, 2) != 0);
         if (s_busy || (sel_req[3+AW+DW+BW-1 -: 3] != CMD_IDLE && P_acc)) begin
            case ($urandom_range(0, 3))
               2:       P_resp = R_DVA;
               3:       P_resp = R_ERR;
               default: P_resp = R_NULL;
            endcase
         end else begin
            P_resp = R_NULL;
         end
         P_SData = $urandom;
         #1;
         e_grant = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
         e_req   = '0;
         if (owner == 1 && !accepted) e_req = {I_MCmd, I_MAddr, I_MData, I_MByteEn};
         if (owner == 2 && !accepted) e_req = {D_MCmd, D_MAddr, D_MData, D_MByteEn};
         e_iacc = (owner == 1 && !accepted) ? P_acc : (I_MCmd == CMD_IDLE);
         e_dacc = (owner == 2 && !accepted) ? P_acc : (D_MCmd == CMD_IDLE);
         e_irsp = (owner == 1) ? {P_resp, P_SData} : '0;
         e_drsp = (owner == 2) ? {P_resp, P_SData} : '0;
         n_tests++;
         if (sel_grant !== e_grant) begin
            n_fail++; $display("FAIL rand%0d_grant c%0d: got %b expected %b", mode, c, sel_grant, e_grant);
         end
         n_tests++;
         if (sel_req !== e_req) begin
            n_fail++; $display("FAIL rand%0d_preq c%0d: got %h expected %h", mode, c, sel_req, e_req);
         end
         n_tests++;
         if (sel_I_acc !== e_iacc || sel_D_acc !== e_dacc) begin
            n_fail++; $display("FAIL rand%0d_accept c%0d: got %b%b expected %b%b", mode, c, sel_I_acc, sel_D_acc, e_iacc, e_dacc);
         end
         n_tests++;
         if (sel_I_rsp !== e_irsp || sel_D_rsp !== e_drsp) begin
            n_fail++; $display("FAIL rand%0d_resp c%0d: got %h/%h expected %h/%h", mode, c, sel_I_rsp, sel_D_rsp, e_irsp, e_drsp);
         end
         si_acc = sel_I_acc; sd_acc = sel_D_acc; si_rsp = sel_I_rsp; sd_rsp = sel_D_rsp;
         sp_cmd = sel_req[3+AW+DW+BW-1 -: 3];
         ip = (I_MCmd != CMD_IDLE);
         dp = (D_MCmd != CMD_IDLE);
         if (owner == 0) begin
            gi = ip && (!dp || (mode ? (starve == LIMIT_PR) : last_d));
            accepted = 0;
            if (gi) begin
               owner = 1; last_d = 0; starve = 0;
            end else if (dp) begin
               owner = 2; last_d = 1;
               starve = ip ? ((starve >= 15) ? 15 : starve + 1) : 0;
            end else begin
               starve = 0;
            end
         end else if (!accepted) begin
            if (P_acc) begin
               if (P_resp != R_NULL) owner = 0;
               else accepted = 1;
            end
         end else if (P_resp != R_NULL) begin
            owner = 0; accepted = 0;
         end
         i_drop = ip && si_acc;
         if (i_drop) i_wait = (si_rsp[2+DW-1 -: 2] == R_NULL);
         else if (i_wait && si_rsp[2+DW-1 -: 2] != R_NULL) i_wait = 0;
         d_drop = dp && sd_acc;
         if (d_drop) d_wait = (sd_rsp[2+DW-1 -: 2] == R_NULL);
         else if (d_wait && sd_rsp[2+DW-1 -: 2] != R_NULL) d_wait = 0;
         if (!s_busy && sp_cmd != CMD_IDLE && P_acc) s_busy = (P_resp == R_NULL);
         else if (s_busy && P_resp != R_NULL) s_busy = 0;
         tick();
         if (i_drop) begin I_MCmd = CMD_IDLE; I_MAddr = '0; I_MData = '0; I_MByteEn = '0; end
         if (d_drop) begin D_MCmd = CMD_IDLE; D_MAddr = '0; D_MData = '0; D_MByteEn = '0; end
      end
      idle_inputs();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_i_read();
      test_rr_alternation();
      test_prio_starve();
      test_accept_stall();
      test_err_same_cycle();
      test_reset_mid_rsp();
      test_random(1'b0, 500);
      test_random(1'b1, 500);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
